// File: rtl/axis_parity_demux_if.sv
// ---------------------------------------------------------------------------
// axis_parity_demux_if
// One AXI4-Stream link (valid/ready/data/last). The demux uses it three times:
// once as the upstream slave port and once per parity-specific master port.
//   tvalid  beat valid, driven by the master
//   tready  beat accepted on tvalid && tready, driven by the slave
//   tdata   DATA_W payload, driven by the master
//   tlast   last beat of a packet, driven by the master
// ---------------------------------------------------------------------------
interface axis_parity_demux_if #(
    parameter int DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_parity_demux.sv
// ---------------------------------------------------------------------------
// axis_parity_demux
// AXI4-Stream parity splitter. Each accepted input beat goes to the odd master
// when the XOR of its tdata is 1, otherwise to the even master. Each master has
// its own DEPTH-entry FIFO so the two sinks stall independently; beat order is
// preserved within each stream and tlast travels only with its own beat.
//
// Ports
//   a_clk         rising-edge clock
//   axis_aresetn  asynchronous active-low reset; empties both FIFOs
//   axis_s        slave stream (input beats)
//   axis_m_odd    master stream for odd-parity beats
//   axis_m_even   master stream for even-parity beats
//   level_odd     odd FIFO occupancy, 0..DEPTH
//   level_even    even FIFO occupancy, 0..DEPTH
//   pkt_cnt_odd   tlast beats popped from the odd master, wraps
//   pkt_cnt_even  tlast beats popped from the even master, wraps
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// axis_parity_demux_fifo
// Per-channel output FIFO with a show-ahead read port and a packet counter.
//   i_push        store {i_last, i_data} on this edge
//   i_ready       downstream ready; a pop happens on o_valid && i_ready
//   o_valid       FIFO not empty
//   o_data/o_last head entry, forced to zero while empty
//   o_level       current occupancy
//   o_level_next  occupancy after the current edge's push/pop
//   o_pkt_cnt     number of popped beats carrying tlast
// ---------------------------------------------------------------------------
module axis_parity_demux_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                   a_clk,
    input  logic                   axis_aresetn,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_last,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_last,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [$clog2(DEPTH):0] o_level_next,
    output logic [CNT_W-1:0]       o_pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Entry layout: {last, data}
    logic [DATA_W:0]  r_mem [DEPTH];
    logic [LW-1:0]    r_wr_cnt;
    logic [LW-1:0]    r_rd_cnt;
    logic [CNT_W-1:0] r_pkt_cnt;

    logic [AW-1:0]    w_wr_ptr;
    logic [AW-1:0]    w_rd_ptr;
    logic [LW-1:0]    w_level;
    logic             w_empty;
    logic             w_pop;
    logic [DATA_W:0]  w_head;

    // Counters carry one extra bit so full (DEPTH) and empty (0) differ;
    // the pointers are just the low bits and wrap modulo DEPTH.
    assign w_wr_ptr = r_wr_cnt[AW-1:0];
    assign w_rd_ptr = r_rd_cnt[AW-1:0];
    assign w_level  = r_wr_cnt - r_rd_cnt;
    assign w_empty  = (w_level == '0);
    assign w_pop    = !w_empty && i_ready;
    assign w_head   = r_mem[w_rd_ptr];

    assign o_valid      = !w_empty;
    assign o_data       = w_empty ? '0 : w_head[DATA_W-1:0];
    assign o_last       = w_empty ? 1'b0 : w_head[DATA_W];
    assign o_level      = w_level;
    assign o_level_next = w_level + LW'(i_push) - LW'(w_pop);
    assign o_pkt_cnt    = r_pkt_cnt;

    // Storage needs no reset: an entry is only visible once written.
    always_ff @(posedge a_clk) begin
        if (i_push) begin
            r_mem[w_wr_ptr] <= {i_last, i_data};
        end
    end

    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wr_cnt <= r_wr_cnt + LW'(1);
            end
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + LW'(1);
                if (w_head[DATA_W]) begin
                    r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

module axis_parity_demux #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                   a_clk,
    input  logic                   axis_aresetn,
    axis_parity_demux_if.slave     axis_s,
    axis_parity_demux_if.master    axis_m_odd,
    axis_parity_demux_if.master    axis_m_even,
    output logic [$clog2(DEPTH):0] level_odd,
    output logic [$clog2(DEPTH):0] level_even,
    output logic [CNT_W-1:0]       pkt_cnt_odd,
    output logic [CNT_W-1:0]       pkt_cnt_even
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic          r_s_tready;
    logic          w_parity;
    logic          w_push;
    logic          w_push_odd;
    logic          w_push_even;
    logic [LW-1:0] w_lvl_odd;
    logic [LW-1:0] w_lvl_even;
    logic [LW-1:0] w_lvl_next_odd;
    logic [LW-1:0] w_lvl_next_even;
    logic          w_ready_next;

    assign w_parity    = ^axis_s.tdata;
    assign w_push      = axis_s.tvalid && r_s_tready;
    assign w_push_odd  = w_push && w_parity;
    assign w_push_even = w_push && !w_parity;

    // Ready is registered and depends only on FIFO levels, never on tdata.
    // It drops on the edge that fills either FIFO (next level), and stays low
    // for one more edge after a pop from full (current level), so a same-edge
    // pop never rescues it.
    assign w_ready_next = (w_lvl_next_odd  != FULL_LVL) &&
                          (w_lvl_next_even != FULL_LVL) &&
                          (w_lvl_odd       != FULL_LVL) &&
                          (w_lvl_even      != FULL_LVL);

    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_s_tready <= 1'b0;
        end else begin
            r_s_tready <= w_ready_next;
        end
    end

    assign axis_s.tready = r_s_tready;

    axis_parity_demux_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo_odd (
        .a_clk        (a_clk),
        .axis_aresetn (axis_aresetn),
        .i_push       (w_push_odd),
        .i_data       (axis_s.tdata),
        .i_last       (axis_s.tlast),
        .i_ready      (axis_m_odd.tready),
        .o_valid      (axis_m_odd.tvalid),
        .o_data       (axis_m_odd.tdata),
        .o_last       (axis_m_odd.tlast),
        .o_level      (w_lvl_odd),
        .o_level_next (w_lvl_next_odd),
        .o_pkt_cnt    (pkt_cnt_odd)
    );

    axis_parity_demux_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo_even (
        .a_clk        (a_clk),
        .axis_aresetn (axis_aresetn),
        .i_push       (w_push_even),
        .i_data       (axis_s.tdata),
        .i_last       (axis_s.tlast),
        .i_ready      (axis_m_even.tready),
        .o_valid      (axis_m_even.tvalid),
        .o_data       (axis_m_even.tdata),
        .o_last       (axis_m_even.tlast),
        .o_level      (w_lvl_even),
        .o_level_next (w_lvl_next_even),
        .o_pkt_cnt    (pkt_cnt_even)
    );

    assign level_odd  = w_lvl_odd;
    assign level_even = w_lvl_even;
endmodule

// File: tb/tb_axis_parity_demux.sv
module tb_axis_parity_demux;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic a_clk = 1'b0;
    logic axis_aresetn;
    logic [3:0]       level_odd;
    logic [3:0]       level_even;
    logic [CNT_W-1:0] pkt_cnt_odd;
    logic [CNT_W-1:0] pkt_cnt_even;

    axis_parity_demux_if #(.DATA_W(DATA_W)) s_if ();
    axis_parity_demux_if #(.DATA_W(DATA_W)) odd_if ();
    axis_parity_demux_if #(.DATA_W(DATA_W)) even_if ();

    axis_parity_demux #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .a_clk        (a_clk),
        .axis_aresetn (axis_aresetn),
        .axis_s       (s_if),
        .axis_m_odd   (odd_if),
        .axis_m_even  (even_if),
        .level_odd    (level_odd),
        .level_even   (level_even),
        .pkt_cnt_odd  (pkt_cnt_odd),
        .pkt_cnt_even (pkt_cnt_even)
    );

    always #5 a_clk = ~a_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Queues hold {last, data} per channel. Handshakes are predicted at the
    // negedge preceding the edge on which they happen.
    logic [8:0]  q_odd[$];
    logic [8:0]  q_even[$];
    logic [15:0] m_pkt_odd;
    logic [15:0] m_pkt_even;
    bit          prev_ok;
    int          edges;

    always @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) edges <= 0;
        else               edges <= edges + 1;
    end

    always @(negedge a_clk) begin
        int lo;
        int le;
        bit exp_rdy;
        if (!axis_aresetn) begin
            q_odd.delete();
            q_even.delete();
            m_pkt_odd  = '0;
            m_pkt_even = '0;
            prev_ok    = 1'b1;
        end else begin
            lo = q_odd.size();
            le = q_even.size();
            // Ready needs at least one edge since reset, and both FIFOs
            // below DEPTH now and before the last edge.
            exp_rdy = (edges > 0) && (lo < DEPTH) && (le < DEPTH) && prev_ok;
            chk("s_tready", 32'(s_if.tready), 32'(exp_rdy));
            chk("level_odd", 32'(level_odd), 32'(lo));
            chk("level_even", 32'(level_even), 32'(le));
            chk("tvalid_odd", 32'(odd_if.tvalid), 32'(lo > 0));
            chk("tvalid_even", 32'(even_if.tvalid), 32'(le > 0));
            chk("pkt_cnt_odd", 32'(pkt_cnt_odd), 32'(m_pkt_odd));
            chk("pkt_cnt_even", 32'(pkt_cnt_even), 32'(m_pkt_even));
            if (lo > 0) begin
                chk("odd_beat", 32'({odd_if.tlast, odd_if.tdata}), 32'(q_odd[0]));
                if (odd_if.tready) begin
                    if (q_odd[0][8]) m_pkt_odd = m_pkt_odd + 16'd1;
                    void'(q_odd.pop_front());
                end
            end
            if (le > 0) begin
                chk("even_beat", 32'({even_if.tlast, even_if.tdata}), 32'(q_even[0]));
                if (even_if.tready) begin
                    if (q_even[0][8]) m_pkt_even = m_pkt_even + 16'd1;
                    void'(q_even.pop_front());
                end
            end
            if (s_if.tvalid && exp_rdy) begin
                if (($countones(s_if.tdata) % 2) == 1) q_odd.push_back({s_if.tlast, s_if.tdata});
                else                                   q_even.push_back({s_if.tlast, s_if.tdata});
            end
            prev_ok = (lo < DEPTH) && (le < DEPTH);
        end
    end

    // ---------------- drivers ----------------
    bit rnd_rdy = 1'b0;

    always @(posedge a_clk) begin
        if (rnd_rdy) begin
            #1;
            odd_if.tready  = 1'($urandom_range(0, 1));
            even_if.tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the edge that accepted it.
    task automatic send(input logic [7:0] d, input logic l);
        int  n;
        bit  done;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge a_clk);
            if (s_if.tready) done = 1'b1;
            else begin
                n++;
                if (n > 500) begin
                    chk("send_timeout", 32'(n), 32'(0));
                    done = 1'b1;
                end
            end
        end
        tick();
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((level_odd != 0 || level_even != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(level_odd) + 32'(level_even), 32'(0));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       exp_odd;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] odd_bytes[9];

    initial begin
        vecs[0] = '{8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1};
        vecs[2] = '{8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'hA5, 1'b0, 1'b0};
        vecs[7] = '{8'hFE, 1'b0, 1'b1};
        odd_bytes = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h07};

        axis_aresetn   = 1'b0;
        idle();
        odd_if.tready  = 1'b0;
        even_if.tready = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_s_tready", 32'(s_if.tready), 32'(0));
        chk("rst_tvalid_odd", 32'(odd_if.tvalid), 32'(0));
        chk("rst_tvalid_even", 32'(even_if.tvalid), 32'(0));
        chk("rst_tdata_odd", 32'(odd_if.tdata), 32'(0));
        chk("rst_tdata_even", 32'(even_if.tdata), 32'(0));
        chk("rst_levels", 32'(level_odd) + 32'(level_even), 32'(0));
        chk("rst_pkt", 32'(pkt_cnt_odd) + 32'(pkt_cnt_even), 32'(0));
        axis_aresetn = 1'b1;
        @(negedge a_clk);
        chk("rel_ready_low", 32'(s_if.tready), 32'(0));
        @(negedge a_clk);
        chk("rel_ready_high", 32'(s_if.tready), 32'(1));
        tick();

        // table-driven routing: each beat must appear on its parity channel
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].last);
            idle();
            @(negedge a_clk);
            chk("vec_tvalid_odd", 32'(odd_if.tvalid), 32'(vecs[i].exp_odd));
            chk("vec_tvalid_even", 32'(even_if.tvalid), 32'(!vecs[i].exp_odd));
            if (vecs[i].exp_odd) chk("vec_odd_beat", 32'({odd_if.tlast, odd_if.tdata}), 32'({vecs[i].last, vecs[i].data}));
            else                 chk("vec_even_beat", 32'({even_if.tlast, even_if.tdata}), 32'({vecs[i].last, vecs[i].data}));
            tick();
            if (vecs[i].exp_odd) odd_if.tready = 1'b1;
            else                 even_if.tready = 1'b1;
            tick();
            odd_if.tready  = 1'b0;
            even_if.tready = 1'b0;
        end
        tick();
        chk("t1_pkt_odd", 32'(pkt_cnt_odd), 32'(1));
        chk("t1_pkt_even", 32'(pkt_cnt_even), 32'(0));

        // odd FIFO fills, ninth beat held until the consumer releases
        even_if.tready = 1'b1;
        for (int i = 0; i < 8; i++) send(odd_bytes[i], 1'b0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = odd_bytes[8];
        s_if.tlast  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge a_clk);
            chk("full_ready", 32'(s_if.tready), 32'(0));
            chk("full_level", 32'(level_odd), 32'(8));
        end
        tick();
        odd_if.tready = 1'b1;
        send(odd_bytes[8], 1'b1);
        idle();
        wait_drained();
        tick();
        chk("t2_pkt_odd", 32'(pkt_cnt_odd), 32'(2));

        // random interleave with randomly toggling readys
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) send(8'($urandom), 1'($urandom_range(0, 3) == 0));
        idle();
        rnd_rdy = 1'b0;
        tick();
        odd_if.tready  = 1'b1;
        even_if.tready = 1'b1;
        wait_drained();

        // push and pop on the same edge at level 4
        odd_if.tready  = 1'b1;
        even_if.tready = 1'b0;
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        chk("lvl4_fill", 32'(level_even), 32'(4));
        even_if.tready = 1'b1;
        send(8'h09, 1'b0);
        chk("lvl4_pp0", 32'(level_even), 32'(4));
        send(8'h0A, 1'b0);
        chk("lvl4_pp1", 32'(level_even), 32'(4));
        send(8'h0C, 1'b1);
        chk("lvl4_pp2", 32'(level_even), 32'(4));
        idle();
        wait_drained();

        // asynchronous reset with five beats buffered mid-packet
        odd_if.tready  = 1'b0;
        even_if.tready = 1'b0;
        send(8'h03, 1'b0);
        send(8'h01, 1'b0);
        send(8'h05, 1'b0);
        send(8'h0E, 1'b0);
        send(8'h11, 1'b0);
        idle();
        tick();
        chk("pre_rst_odd", 32'(level_odd), 32'(2));
        chk("pre_rst_even", 32'(level_even), 32'(3));
        #2;
        axis_aresetn = 1'b0;
        #1;
        chk("arst_ready", 32'(s_if.tready), 32'(0));
        chk("arst_tvalid", 32'({odd_if.tvalid, even_if.tvalid}), 32'(0));
        chk("arst_tdata", 32'({odd_if.tdata, even_if.tdata}), 32'(0));
        chk("arst_levels", 32'({level_odd, level_even}), 32'(0));
        chk("arst_pkt", 32'({pkt_cnt_odd, pkt_cnt_even}), 32'(0));
        tick();
        tick();
        axis_aresetn   = 1'b1;
        odd_if.tready  = 1'b1;
        even_if.tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge a_clk);
            chk("no_stale", 32'({odd_if.tvalid, even_if.tvalid}), 32'(0));
        end
        tick();

        // pkt_cnt_even wrap after 65536 tlast beats
        axis_aresetn = 1'b0;
        tick();
        axis_aresetn = 1'b1;
        tick();
        for (int i = 0; i < 65536; i++) begin
            send(8'h00, 1'b1);
            if (i == 65535) chk("pkt_cnt_max", 32'(pkt_cnt_even), 32'(16'hFFFF));
        end
        idle();
        tick();
        tick();
        chk("pkt_cnt_wrap", 32'(pkt_cnt_even), 32'(0));
        chk("wrap_pkt_odd", 32'(pkt_cnt_odd), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
